// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vga_timing_pkg
// Brief   : Default VGA timing constants, widths and the pixel pipeline record.
// Revision: 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  localparam int COORD_W = 11;
  localparam int RGB_W   = 12;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  typedef struct packed {
    logic             vis;
    logic             hs;
    logic             vs;
    logic [RGB_W-1:0] rgb;
  } pix_t;

  // Sync flags hold "active", so the cleared record is always the inactive one.
  localparam pix_t PIX_IDLE = '{vis: 1'b0, hs: 1'b0, vs: 1'b0, rgb: {RGB_W{1'b0}}};

  function automatic int h_total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

  function automatic int v_total(input int vis, input int fp, input int sync, input int bp);
    return vis + fp + sync + bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module  : vga_pipe_stage
// Brief   : One pixel-tick-enabled register of the output alignment pipeline.
// Revision: 1.0 - initial release
// ============================================================================
module vga_pipe_stage
  import vga_timing_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  pix_t d_i,
  output pix_t q_o
);

  pix_t stage_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= PIX_IDLE;
    end else if (en_i) begin
      stage_q <= d_i;
    end
  end

  assign q_o = stage_q;

endmodule
`default_nettype wire

// File: rtl/vga_scan_timer.sv
`default_nettype none
// ============================================================================
// Module  : vga_scan_timer
// Brief   : Pixel divider, x/y scan counters, sync/blank decode and output pipe.
// Revision: 1.0 - initial release
// ============================================================================
module vga_scan_timer
  import vga_timing_pkg::*;
#(
  parameter int   CLK_DIV   = 4,
  parameter int   H_VISIBLE = DEF_H_VISIBLE,
  parameter int   H_FP      = DEF_H_FP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BP      = DEF_H_BP,
  parameter int   V_VISIBLE = DEF_V_VISIBLE,
  parameter int   V_FP      = DEF_V_FP,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BP      = DEF_V_BP,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   PIPE      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [RGB_W-1:0]   rgb_in,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               p_tick,
  output logic               frame_tick,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic [RGB_W-1:0]   rgb_out
);

  localparam int c_h_total = h_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int c_v_total = v_total(V_VISIBLE, V_FP, V_SYNC, V_BP);
  localparam int c_div_w   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [c_div_w-1:0] c_div_max  = c_div_w'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] c_h_max    = COORD_W'(c_h_total - 1);
  localparam logic [COORD_W-1:0] c_v_max    = COORD_W'(c_v_total - 1);
  localparam logic [COORD_W-1:0] c_h_vis    = COORD_W'(H_VISIBLE);
  localparam logic [COORD_W-1:0] c_v_vis    = COORD_W'(V_VISIBLE);
  localparam logic [COORD_W-1:0] c_hs_start = COORD_W'(H_VISIBLE + H_FP);
  localparam logic [COORD_W-1:0] c_hs_end   = COORD_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [COORD_W-1:0] c_vs_start = COORD_W'(V_VISIBLE + V_FP);
  localparam logic [COORD_W-1:0] c_vs_end   = COORD_W'(V_VISIBLE + V_FP + V_SYNC);

  logic [c_div_w-1:0] div_q, div_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               w_line_end, w_frame_end;
  logic               w_vis, w_hs_act, w_vs_act;
  pix_t               w_pix0;
  pix_t               w_stage [PIPE];

  // With CLK_DIV = 1 the divider is stuck at zero, which equals its max.
  assign p_tick      = (div_q == c_div_max);
  assign w_line_end  = (x_q == c_h_max);
  assign w_frame_end = (y_q == c_v_max);
  assign frame_tick  = p_tick & w_line_end & w_frame_end;

  always_comb begin
    div_d = (div_q == c_div_max) ? '0 : div_q + 1'b1;
    x_d   = x_q;
    y_d   = y_q;
    if (p_tick) begin
      if (w_line_end) begin
        x_d = '0;
        y_d = w_frame_end ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  assign w_vis    = (x_q < c_h_vis) & (y_q < c_v_vis);
  assign w_hs_act = (x_q >= c_hs_start) & (x_q < c_hs_end);
  assign w_vs_act = (y_q >= c_vs_start) & (y_q < c_vs_end);

  always_comb begin
    w_pix0     = PIX_IDLE;
    w_pix0.vis = w_vis;
    w_pix0.hs  = w_hs_act;
    w_pix0.vs  = w_vs_act;
    w_pix0.rgb = w_vis ? rgb_in : '0;
  end

  for (genvar i = 0; i < PIPE; i++) begin : g_pipe
    if (i == 0) begin : g_first
      vga_pipe_stage u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (p_tick),
        .d_i   (w_pix0),
        .q_o   (w_stage[i])
      );
    end else begin : g_rest
      vga_pipe_stage u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (p_tick),
        .d_i   (w_stage[i-1]),
        .q_o   (w_stage[i])
      );
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign video_on = w_stage[PIPE-1].vis;
  assign hsync    = w_stage[PIPE-1].hs ~^ SYNC_POL;
  assign vsync    = w_stage[PIPE-1].vs ~^ SYNC_POL;
  assign rgb_out  = w_stage[PIPE-1].rgb;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_timer.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_scan_timer
// Brief   : Self-checking bench for vga_scan_timer across three configurations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vga_scan_timer;

  localparam int SM_HV = 16, SM_HF = 2, SM_HS = 3, SM_HB = 3;
  localparam int SM_VV = 8,  SM_VF = 2, SM_VS = 2, SM_VB = 3;
  localparam int SM_HT = SM_HV + SM_HF + SM_HS + SM_HB;
  localparam int SM_VT = SM_VV + SM_VF + SM_VS + SM_VB;
  localparam int SM_PIPE = 3;
  localparam logic SM_POL = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // default configuration: CLK_DIV=4, PIPE=1
  logic        rst_def;
  logic [11:0] rgb_def;
  logic [10:0] x_def, y_def;
  logic        pt_def, ft_def, von_def, hs_def, vs_def;
  logic [11:0] rgbo_def;

  vga_scan_timer u_def (
    .clk(clk), .rst_n(rst_def), .rgb_in(rgb_def), .x(x_def), .y(y_def),
    .p_tick(pt_def), .frame_tick(ft_def), .video_on(von_def),
    .hsync(hs_def), .vsync(vs_def), .rgb_out(rgbo_def)
  );

  // full-size timing, one pixel per clock
  logic        rst_c1;
  logic [11:0] rgb_c1;
  logic [10:0] x_c1, y_c1;
  logic        pt_c1, ft_c1, von_c1, hs_c1, vs_c1;
  logic [11:0] rgbo_c1;

  vga_scan_timer #(.CLK_DIV(1), .PIPE(1)) u_c1 (
    .clk(clk), .rst_n(rst_c1), .rgb_in(rgb_c1), .x(x_c1), .y(y_c1),
    .p_tick(pt_c1), .frame_tick(ft_c1), .video_on(von_c1),
    .hsync(hs_c1), .vsync(vs_c1), .rgb_out(rgbo_c1)
  );

  // shrunken timing so whole frames fit; deep pipe, active-high sync
  logic        rst_sm;
  logic [11:0] rgb_sm;
  logic [10:0] x_sm, y_sm;
  logic        pt_sm, ft_sm, von_sm, hs_sm, vs_sm;
  logic [11:0] rgbo_sm;

  vga_scan_timer #(
    .CLK_DIV(1), .H_VISIBLE(SM_HV), .H_FP(SM_HF), .H_SYNC(SM_HS), .H_BP(SM_HB),
    .V_VISIBLE(SM_VV), .V_FP(SM_VF), .V_SYNC(SM_VS), .V_BP(SM_VB),
    .SYNC_POL(SM_POL), .PIPE(SM_PIPE)
  ) u_sm (
    .clk(clk), .rst_n(rst_sm), .rgb_in(rgb_sm), .x(x_sm), .y(y_sm),
    .p_tick(pt_sm), .frame_tick(ft_sm), .video_on(von_sm),
    .hsync(hs_sm), .vsync(vs_sm), .rgb_out(rgbo_sm)
  );

  assign rgb_sm = {x_sm[3:0], y_sm[3:0], 4'hA};

  // ---------------- scoreboard for u_sm ----------------
  typedef struct packed {
    logic        vis;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  exp_t sb_q[$];
  bit   sb_en = 1'b0;
  int   mx, my, sb_cycle, ft_cnt, ft_last, ft_gap;

  always @(negedge clk) begin
    if (sb_en) begin
      exp_t e;
      exp_t o;
      logic [3:0] mx4, my4;
      mx4 = mx[3:0];
      my4 = my[3:0];
      chk("sm_x", 32'(x_sm), mx);
      chk("sm_y", 32'(y_sm), my);
      chk("sm_ptick", 32'(pt_sm), 1);
      chk("sm_frame_tick", 32'(ft_sm), ((mx == SM_HT-1) && (my == SM_VT-1)) ? 1 : 0);
      if (ft_sm === 1'b1) begin
        ft_cnt++;
        ft_gap  = sb_cycle - ft_last;
        ft_last = sb_cycle;
      end
      e.vis = (mx < SM_HV) && (my < SM_VV);
      e.hs  = (mx >= SM_HV+SM_HF) && (mx < SM_HV+SM_HF+SM_HS);
      e.vs  = (my >= SM_VV+SM_VF) && (my < SM_VV+SM_VF+SM_VS);
      e.rgb = e.vis ? {mx4, my4, 4'hA} : 12'h000;
      sb_q.push_back(e);
      if (sb_q.size() > SM_PIPE) begin
        o = sb_q.pop_front();
        chk("sm_video_on", 32'(von_sm), 32'(o.vis));
        chk("sm_hsync", 32'(hs_sm), 32'(SM_POL ? o.hs : ~o.hs));
        chk("sm_vsync", 32'(vs_sm), 32'(SM_POL ? o.vs : ~o.vs));
        chk("sm_rgb_out", 32'(rgbo_sm), 32'(o.rgb));
      end
      if (mx == SM_HT-1) begin
        mx = 0;
        my = (my == SM_VT-1) ? 0 : my + 1;
      end else begin
        mx++;
      end
      sb_cycle++;
    end
  end

  // ---------------- vector table for u_c1 ----------------
  typedef struct {
    int          x;
    logic [11:0] rgb;
    logic        von;
    logic        hs;
    logic        vs;
    logic [11:0] rgb_exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int to;
    vecs[0] = '{0,   12'h5A5, 1'b1, 1'b1, 1'b1, 12'h5A5};
    vecs[1] = '{100, 12'hFFF, 1'b1, 1'b1, 1'b1, 12'hFFF};
    vecs[2] = '{639, 12'h123, 1'b1, 1'b1, 1'b1, 12'h123};
    vecs[3] = '{640, 12'hFFF, 1'b0, 1'b1, 1'b1, 12'h000};
    vecs[4] = '{655, 12'hFFF, 1'b0, 1'b1, 1'b1, 12'h000};
    vecs[5] = '{656, 12'hFFF, 1'b0, 1'b0, 1'b1, 12'h000};
    vecs[6] = '{700, 12'hFFF, 1'b0, 1'b0, 1'b1, 12'h000};
    vecs[7] = '{751, 12'hFFF, 1'b0, 1'b0, 1'b1, 12'h000};
    vecs[8] = '{752, 12'hFFF, 1'b0, 1'b1, 1'b1, 12'h000};
    vecs[9] = '{799, 12'hFFF, 1'b0, 1'b1, 1'b1, 12'h000};

    rst_def = 1'b0; rst_c1 = 1'b0; rst_sm = 1'b0;
    rgb_def = 12'hFFF; rgb_c1 = 12'hFFF;

    // reset state
    repeat (10) @(posedge clk);
    #1;
    chk("rst_x", 32'(x_def), 0);
    chk("rst_y", 32'(y_def), 0);
    chk("rst_hsync", 32'(hs_def), 1);
    chk("rst_vsync", 32'(vs_def), 1);
    chk("rst_video_on", 32'(von_def), 0);
    chk("rst_rgb_out", 32'(rgbo_def), 0);
    chk("rst_ptick", 32'(pt_def), 0);
    chk("rst_frame_tick", 32'(ft_def), 0);
    chk("rst_c1_ptick", 32'(pt_c1), 1);
    chk("rst_sm_hsync", 32'(hs_sm), 0);

    // divider: p_tick every 4th clock, x advances once per 4 clocks
    rst_def = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("div_ptick", 32'(pt_def), ((i % 4) == 3) ? 1 : 0);
    end
    chk("div_x_after_40", 32'(x_def), 9);

    // mid-line asynchronous reset at x = 300
    to = 0;
    while (x_def != 11'd300 && to < 2000) begin
      @(negedge clk);
      to++;
    end
    if (to >= 2000) begin
      total++; bad++;
      $display("FAIL def_wait_x300: got x=%0d want 300", x_def);
    end
    chk("mid_video_on", 32'(von_def), 1);
    chk("mid_rgb_out", 32'(rgbo_def), 32'hFFF);
    rst_def = 1'b0;
    #1;
    chk("async_x", 32'(x_def), 0);
    chk("async_video_on", 32'(von_def), 0);
    chk("async_rgb_out", 32'(rgbo_def), 0);
    chk("async_ptick", 32'(pt_def), 0);
    repeat (2) @(posedge clk);
    #1 rst_def = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("restart_x", 32'(x_def), 1);
    chk("restart_y", 32'(y_def), 0);

    // full-size line sweep with one pixel per clock
    @(posedge clk);
    #1 rst_c1 = 1'b1;
    for (int v = 0; v < 10; v++) begin
      to = 0;
      while (int'(x_c1) != vecs[v].x && to < 2000) begin
        @(posedge clk);
        #1;
        to++;
      end
      if (to >= 2000) begin
        total++; bad++;
        $display("FAIL c1_wait_x: got x=%0d want %0d", x_c1, vecs[v].x);
      end
      rgb_c1 = vecs[v].rgb;
      @(posedge clk);
      #1;
      chk("c1_x_step", 32'(x_c1), (vecs[v].x + 1) % 800);
      chk("c1_video_on", 32'(von_c1), 32'(vecs[v].von));
      chk("c1_hsync", 32'(hs_c1), 32'(vecs[v].hs));
      chk("c1_vsync", 32'(vs_c1), 32'(vecs[v].vs));
      chk("c1_rgb_out", 32'(rgbo_c1), 32'(vecs[v].rgb_exp));
    end

    // three complete small frames through the scoreboard
    @(posedge clk);
    #1;
    rst_sm   = 1'b1;
    mx       = 0;
    my       = 0;
    sb_cycle = 0;
    ft_cnt   = 0;
    ft_last  = 0;
    ft_gap   = 0;
    for (int i = 0; i < SM_PIPE; i++) sb_q.push_back('0);
    sb_en = 1'b1;
    repeat (3 * SM_HT * SM_VT) @(posedge clk);
    #1;
    sb_en = 1'b0;
    chk("sm_frame_count", 32'(ft_cnt), 3);
    chk("sm_frame_period", 32'(ft_gap), SM_HT * SM_VT);
    chk("sm_first_ft", 32'(ft_last), 3 * SM_HT * SM_VT - 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_scan_timer.md
Name: vga_scan_timer

Overview:
- Produces the pixel scan coordinates and the VGA sync and blanking signals that drive every per-pixel colour source in the Tetris display.
- Pixel sources are combinational functions of (x, y). This block sweeps x/y, samples the source colour, blanks it outside the visible region, and aligns rgb with hsync/vsync through a parameterised pipeline.
- It sits between the system clock and the VGA connector, upstream and downstream of all pixel sources.

Parameters:
- CLK_DIV, 4, system clocks per pixel (1 = one pixel per clock).
- H_VISIBLE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_VISIBLE, 480, visible lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync width (lines).
- V_BP, 33, vertical back porch (lines).
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low).
- PIPE, 1, output pipeline depth in pixel ticks (>= 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rgb_in  in  12  colour from the pixel sources for the current x, y
- x  out  11  horizontal count, 0..H_TOTAL-1
- y  out  11  vertical count, 0..V_TOTAL-1
- p_tick  out  1  one-clock pixel enable
- frame_tick  out  1  one-clock pulse at the end of each frame
- video_on  out  1  visible region, pipeline-aligned
- hsync  out  1  horizontal sync, pipeline-aligned
- vsync  out  1  vertical sync, pipeline-aligned
- rgb_out  out  12  blanked colour, pipeline-aligned

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Derived constants: H_TOTAL = sum of the four H_ parameters (default 800). V_TOTAL = sum of the four V_ parameters (default 525).
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - p_tick = (div == CLK_DIV-1).
  - With CLK_DIV = 1, p_tick is constantly 1 after reset.
- Counters:
  - On p_tick, x increments. When x == H_TOTAL-1, x wraps to 0 and y increments.
  - When y == V_TOTAL-1 on that same wrap, y also wraps to 0.
  - x and y are registers and change only on p_tick.
- Frame tick:
  - frame_tick = p_tick & (x == H_TOTAL-1) & (y == V_TOTAL-1), combinational.
  - It is high for exactly one clock per frame.
- Raw decodes, from the current x, y:
  - vis = (x < H_VISIBLE) & (y < V_VISIBLE).
  - hs_act = (H_VISIBLE+H_FP <= x < H_VISIBLE+H_FP+H_SYNC).
  - vs_act = the same window applied to y with the V_ parameters.
- Pipeline, stage 1 (advances only on p_tick):
  - Captures vis, hs_act, vs_act.
  - Captures rgb_in if vis, else 12'h000.
- Stages 2..PIPE: a plain shift of all four fields on p_tick.
- Outputs are the last stage:
  - hsync = hs_act_stage XNOR SYNC_POL, i.e. equal to SYNC_POL when active; likewise vsync.
  - video_on and rgb_out come straight from the last stage.
- Latency: PIPE pixel ticks from the (x, y) presentation to the corresponding outputs. Colour sources must therefore be purely combinational on x, y.
- Reset values:
  - div = 0, x = 0, y = 0.
  - p_tick = 0 when CLK_DIV > 1; when CLK_DIV = 1 it is 1 (constant).
  - frame_tick = 0.
  - All stages cleared: video_on = 0, rgb_out = 0, hsync = vsync = inactive (~SYNC_POL).
- Reset mid-frame: all state returns to the reset values immediately and asynchronously. Scanning restarts at (0, 0) on release, with no partial-line artefact beyond the flush.
- Outputs are glitch-free; every output is registered except p_tick and frame_tick, which decode registers only.

Decomposition:
- Package vga_timing_pkg:
  - Default timing constants and H_TOTAL/V_TOTAL functions.
  - COORD_W = 11, RGB_W = 12.
  - Packed struct pix_t {vis, hs, vs, rgb}.
- Sub-module vga_pipe_stage: a p_tick-enabled register of pix_t with async clear to the inactive value, instantiated PIPE times via generate.

Test Plan:
- Reset: hold rst_n = 0 for 10 clocks -> x = 0, y = 0, hsync = vsync = 1, video_on = 0, rgb_out = 000; assert rst_n mid-line at x = 300 -> x returns to 0 in the same cycle.
- Divider: CLK_DIV = 4 -> p_tick high exactly every 4th clk; x advances by 1 per 4 clks; CLK_DIV = 1 -> x advances every clock.
- Sync window, PIPE = 1, CLK_DIV = 1:
  - hsync goes low on the clock after x = 656 is presented and stays low for 96 pixels.
  - vsync goes low for exactly 2 full lines (1600 pixels) starting at y = 490.
- Wrap: at x = 799, y = 524 -> frame_tick pulses once; next p_tick gives x = 0, y = 0; frame_tick count over 3 frames = 3; period = 420000 clks at CLK_DIV = 1.
- Blanking: rgb_in = FFF constant -> rgb_out = FFF for x < 640, y < 480; rgb_out = 000 at x = 700 and at y = 500.
- Alignment: PIPE = 3, rgb_in = {x[3:0], 8'h00} -> rgb_out and video_on lag x by exactly 3 p_ticks; hsync edges shift by the same 3 pixels.
